uart_tx_word_serializer: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 30 +++
 rtl/tx_word_fifo.sv | 68 ++++++
 rtl/uart_tx_word_serializer.sv | 133 +++++++++++++
 tb/tb_uart_tx_word_serializer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART word serializer.
// Holds the serializer state enum, per-word byte counts for the binary and
// hex framings, the ASCII constants used by hex framing and the
// nibble-to-ASCII helper.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } tx_state_e;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned BIN_BYTES_PER_WORD = 4;
  localparam int unsigned HEX_BYTES_PER_WORD = 9;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_A_LOWER = 8'h61;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  // Lowercase hex digit for one nibble.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    logic [7:0] res;
    if (nib < 4'd10) res = ASCII_ZERO + {4'd0, nib};
    else             res = ASCII_A_LOWER + {4'd0, nib} - 8'd10;
    return res;
  endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// Generic synchronous FIFO with registered full/empty flags.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   push, wr_data     write request and data (ignored while full)
//   pop, rd_data      read request (ignored while empty), head-of-queue data
//   full, empty       registered occupancy flags
module tx_word_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  do_push_c;
  logic                  do_pop_c;

  assign do_push_c = push & ~full;
  assign do_pop_c  = pop & ~empty;
  assign rd_data   = mem[rd_ptr_q];

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, count and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      count_q <= count_d;
      full    <= (count_d == CNT_W'(DEPTH));
      empty   <= (count_d == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_word_serializer.sv
// Buffers 32-bit result words and feeds them byte by byte to the UART
// transmitter over a one-cycle new-byte strobe / ready handshake.
// Build option: UART_TX_HEX_EN selects 9-byte lowercase ASCII hex framing
// ("deadbeef\n"); without it each word goes out as 4 raw bytes, MSB first.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid, in_word       word offered by the hashing core
//   in_ready                FIFO not full (registered)
//   tx_ready                transmitter can take a byte
//   tx_new_byte, tx_byte    one-cycle strobe with byte, byte held afterwards
//   busy                    FIFO non-empty or serializer active
//   overflow_count          saturating count of words dropped on a full FIFO
module uart_tx_word_serializer
  import uart_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  input  logic              tx_ready,
  output logic              tx_new_byte,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              busy,
  output logic [7:0]        overflow_count
);

`ifdef UART_TX_HEX_EN
  localparam int unsigned BYTES_PER_WORD = HEX_BYTES_PER_WORD;
  localparam int unsigned SHIFT_W        = 4;
`else
  localparam int unsigned BYTES_PER_WORD = BIN_BYTES_PER_WORD;
  localparam int unsigned SHIFT_W        = 8;
`endif
  localparam int unsigned     IDX_W    = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  tx_state_e         state_q;
  tx_state_e         state_d;
  logic [WORD_W-1:0] shreg_q;
  logic [IDX_W-1:0]  idx_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rd_data;
  logic              push_c;
  logic              load_c;
  logic              strobe_c;
  logic [BYTE_W-1:0] next_byte_c;

  assign push_c   = in_valid & ~fifo_full;
  assign in_ready = ~fifo_full;
  assign busy     = ~fifo_empty | (state_q != IDLE);

  tx_word_fifo #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_c),
    .wr_data (in_word),
    .pop     (load_c),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Byte to emit next; shift register always holds the unsent part at the top.
  always_comb begin
    next_byte_c = '0;
`ifdef UART_TX_HEX_EN
    if (idx_q == LAST_IDX) next_byte_c = ASCII_LF;
    else                   next_byte_c = nib2ascii(shreg_q[WORD_W-1 -: 4]);
`else
    next_byte_c = shreg_q[WORD_W-1 -: BYTE_W];
`endif
  end

  // Serializer state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and control; a strobe is never issued while the previous one is high.
  always_comb begin
    state_d  = state_q;
    load_c   = 1'b0;
    strobe_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = LOAD;
      end
      LOAD: begin
        load_c  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (tx_ready && !tx_new_byte) begin
          strobe_c = 1'b1;
          if (idx_q == LAST_IDX) state_d = fifo_empty ? IDLE : LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift register, byte index, output byte/strobe and overflow counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q        <= '0;
      idx_q          <= '0;
      tx_new_byte    <= 1'b0;
      tx_byte        <= '0;
      overflow_count <= '0;
    end else begin
      tx_new_byte <= strobe_c;
      if (load_c) begin
        shreg_q <= fifo_rd_data;
        idx_q   <= '0;
      end else if (strobe_c) begin
        tx_byte <= next_byte_c;
        shreg_q <= shreg_q << SHIFT_W;
        idx_q   <= idx_q + IDX_W'(1);
      end
      if (in_valid && fifo_full && (overflow_count != 8'hFF))
        overflow_count <= overflow_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_tx_word_serializer.sv
// Randomized self-checking bench for uart_tx_word_serializer with a
// byte-queue reference model and a behavioural transmitter.
module tb_uart_tx_word_serializer;

`ifdef UART_TX_HEX_EN
  localparam int BYTES = 9;
`else
  localparam int BYTES = 4;
`endif
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_word;
  logic        in_ready;
  logic        tx_ready;
  logic        tx_new_byte;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [7:0]  overflow_count;

  uart_tx_word_serializer #(.FIFO_DEPTH_LOG2(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_word        (in_word),
    .in_ready       (in_ready),
    .tx_ready       (tx_ready),
    .tx_new_byte    (tx_new_byte),
    .tx_byte        (tx_byte),
    .busy           (busy),
    .overflow_count (overflow_count)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_bad    = 0;
  int         cyc      = 0;
  int         n_strobes = 0;
  logic [7:0] exp_q[$];
  int         st_q[$];
  logic [7:0] last_b = 8'h00;
  bit         mon_en = 1'b0;
  bit         tx_en = 1'b0;
  bit         tx_hold = 1'b1;
  int         baud = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected i-th byte of a word, straight from the framing rules.
  function automatic logic [7:0] model_byte(input logic [31:0] w, input int i);
`ifdef UART_TX_HEX_EN
    int d;
    if (i == 8) return 8'd10;
    d = int'((w >> (28 - 4 * i)) & 32'hF);
    if (d < 10) return 8'(48 + d);
    return 8'(97 + d - 10);
`else
    return 8'((w >> (24 - 8 * i)) & 32'hFF);
`endif
  endfunction

  function automatic void model_push(input logic [31:0] w);
    for (int i = 0; i < BYTES; i++) exp_q.push_back(model_byte(w, i));
  endfunction

  function automatic int outstanding_words();
    return (exp_q.size() + BYTES - 1) / BYTES;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Transmitter: ready drops on a strobe and returns after 'baud' cycles.
  int tx_left = 0;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (tx_new_byte === 1'b1) tx_left = baud;
      else if (tx_left > 0)     tx_left--;
      if (tx_hold) tx_ready = tx_en;
      else         tx_ready = tx_en && (tx_left == 0) && (tx_new_byte !== 1'b1);
    end
  end

  // Strobe monitor: byte order, handshake legality and byte hold.
  initial begin
    logic       prev_stb;
    logic       prev_rdy;
    logic [7:0] eb;
    prev_stb = 1'b0;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (tx_new_byte === 1'b1) begin
          check("strobe_adjacent", 32'(prev_stb), 32'd0);
          check("strobe_ready", 32'(prev_rdy), 32'd1);
          check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            eb = exp_q.pop_front();
            check("tx_byte", 32'(tx_byte), 32'(eb));
            last_b = eb;
          end
          st_q.push_back(cyc);
          n_strobes++;
        end else begin
          check("tx_byte_hold", 32'(tx_byte), 32'(last_b));
        end
      end
      prev_stb = tx_new_byte;
      prev_rdy = tx_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    last_b = 8'h00;
  endtask

  // Offers one word for one cycle; the model says it must be accepted.
  task automatic push_word(input logic [31:0] w, output int acc_cyc);
    in_valid = 1'b1;
    in_word  = w;
    check("in_ready_push", 32'(in_ready), 32'd1);
    @(posedge clk);
    model_push(w);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      tick(1);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    tick(3);
    check("busy_after_drain", 32'(busy), 32'd0);
  endtask

  task automatic check_gaps(input string tag, input int first, input int n, input int gap);
    check({tag, "_count"}, 32'(st_q.size()), 32'(n));
    if (st_q.size() == n) begin
      check({tag, "_first"}, 32'(st_q[0]), 32'(first));
      for (int i = 1; i < n; i++) check({tag, "_gap"}, 32'(st_q[i] - st_q[i-1]), 32'(gap));
    end
  endtask

  initial begin
    int t0;
    int t1;
    int n;
    int base;
    logic [31:0] w;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_word  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_new_byte", 32'(tx_new_byte), 32'd0);
    check("rst_tx_byte", 32'(tx_byte), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow_count), 32'd0);
    mon_en = 1'b1;

    // Single word with ready held high: latency and spacing.
    tx_hold = 1'b1;
    tx_en   = 1'b1;
    tick(2);
    st_q.delete();
    push_word(32'hDEADBEEF, t0);
    drain(200);
    check_gaps("single", t0 + 3, BYTES, 2);

    // Two words back to back, ready held: one LOAD cycle between words.
    st_q.delete();
    push_word(32'h0123ABCD, t0);
    push_word(32'hCAFEF00D, t1);
    drain(200);
    check_gaps("b2b_hold", t0 + 3, 2 * BYTES, 2);

    // Two words back to back with a slow transmitter.
    tx_hold = 1'b0;
    baud    = 40;
    tick(50);
    st_q.delete();
    push_word(32'h89ABCDEF, t0);
    push_word(32'h01234567, t1);
    drain(2000);
    check_gaps("b2b_baud", t0 + 3, 2 * BYTES, 41);

    // FIFO full: one word parked in the serializer, then 10 offered.
    tx_en   = 1'b0;
    tx_hold = 1'b1;
    tick(2);
    push_word(32'hA5A5_0000, t0);
    tick(4);
    for (int i = 0; i < 10; i++) begin
      w        = $urandom;
      in_valid = 1'b1;
      in_word  = w;
      @(posedge clk);
      if (i < DEPTH) model_push(w);
      #1;
      check("in_ready_fill", 32'(in_ready), (i < DEPTH - 1) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    check("overflow_two", 32'(overflow_count), 32'd2);
    check("busy_full", 32'(busy), 32'd1);
    tx_hold = 1'b0;
    baud    = 3;
    tx_en   = 1'b1;
    drain(3000);
    check("in_ready_drained", 32'(in_ready), 32'd1);

    // Overflow saturation.
    do_reset();
    check("overflow_cleared", 32'(overflow_count), 32'd0);
    tx_en   = 1'b0;
    tx_hold = 1'b1;
    tick(2);
    push_word(32'h5A5A_1111, t0);
    tick(4);
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH + 300; i++) begin
      in_word = $urandom;
      @(posedge clk);
      #1;
      if (i == DEPTH + 99) check("overflow_100", 32'(overflow_count), 32'd100);
    end
    in_valid = 1'b0;
    check("overflow_sat", 32'(overflow_count), 32'd255);
    do_reset();
    check("sat_rst_overflow", 32'(overflow_count), 32'd0);
    check("sat_rst_in_ready", 32'(in_ready), 32'd1);
    check("sat_rst_busy", 32'(busy), 32'd0);

    // Reset one cycle after the second strobe of a word.
    tx_en   = 1'b1;
    tx_hold = 1'b0;
    baud    = 2;
    tick(5);
    base = n_strobes;
    push_word(32'hFEEDFACE, t0);
    n = 0;
    while (n_strobes < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("rst_wait_strobes", 32'(n_strobes - base), 32'd2);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    last_b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      check("midrst_new_byte", 32'(tx_new_byte), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      tick(1);
    end
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    push_word(32'h13579BDF, t0);
    drain(500);

    // Randomized traffic with varying transmitter speed.
    for (int k = 0; k < 40; k++) begin
      tx_hold = ($urandom_range(0, 3) == 0);
      baud    = int'($urandom_range(0, 6));
      tick(int'($urandom_range(0, 3)));
      n = 0;
      while (outstanding_words() >= DEPTH && n < 2000) begin
        tick(1);
        n++;
      end
      push_word($urandom, t0);
    end
    drain(5000);
    check("final_overflow", 32'(overflow_count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
